control_seq: RTL

Parametrised instruction-cycle sequencer for the accumulator CPU and the successor to the fixed 8-phase control FSM. It keeps the same eight phases, opcode decode and strobe set. It adds a memory wait-state handshake, a bus-timeout watchdog, and a resumable HALTED state. It sits between the instruction register/ALU flags and the PC, AC, IR and memory strobes.

---
 rtl/control_seq.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/control_seq.sv
// rtl/control_seq.sv - 8-phase instruction-cycle sequencer with memory wait states, bus watchdog and HALTED state
// Optional feature: define CONTROL_SEQ_PERF_EN to add the retired-instruction counter instr_cnt.
module control_seq #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic [2:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  input  logic       resume,
  output logic       load_ac,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       load_ir,
  output logic       fetch,
  output logic       halt,
  output logic       bus_err,
  output logic [2:0] phase
`ifdef CONTROL_SEQ_PERF_EN
  ,
  output logic [CNT_W-1:0] instr_cnt
`endif
);

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  // The counter only needs to reach MAX_WAIT-1: the MAX_WAIT-th stall cycle trips the watchdog.
  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("control_seq: CNT_W must be at least 1");
  end

  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic [2:0]        held_phase;
  logic              aluop, stall, timeout;

  assign aluop = (opcode >= OP_ADD) && (opcode <= OP_LDA);
  assign phase = (state_q == HALTED) ? held_phase : state_q[2:0];

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state_q <= INST_ADDR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load_ac = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    inc_pc  = 1'b0;
    load_pc = 1'b0;
    load_ir = 1'b0;
    fetch   = 1'b0;
    halt    = 1'b0;
    unique case (state_q)
      INST_ADDR:  fetch = 1'b1;
      INST_FETCH: begin fetch = 1'b1; mem_rd = 1'b1; end
      INST_LOAD,
      IDLE:       begin fetch = 1'b1; mem_rd = 1'b1; load_ir = 1'b1; end
      OP_ADDR:    begin inc_pc = 1'b1; halt = (opcode == OP_HLT); end
      OP_FETCH:   mem_rd = aluop;
      ALU_OP:     begin
        mem_rd  = aluop;
        inc_pc  = (opcode == OP_SKZ) && zero;
        load_pc = (opcode == OP_JMP);
      end
      STORE:      begin
        mem_rd  = aluop;
        mem_wr  = (opcode == OP_STO);
        load_ac = aluop && mem_ready;
        load_pc = (opcode == OP_JMP);
      end
      default:    halt = 1'b1;
    endcase

    stall = !mem_ready && ((state_q == INST_FETCH) ||
                           ((state_q == OP_FETCH) && mem_rd) ||
                           ((state_q == STORE) && (mem_rd || mem_wr)));
    timeout = stall && (MAX_WAIT != 0) && (wait_cnt == WAIT_LAST);

    if (state_q == HALTED) begin
      if (resume) state_d = INST_ADDR;
    end else if (stall) begin
      if (timeout) state_d = HALTED;
    end else if ((state_q == OP_ADDR) && (opcode == OP_HLT)) begin
      state_d = HALTED;
    end else begin
      unique case (state_q)
        INST_ADDR:  state_d = INST_FETCH;
        INST_FETCH: state_d = INST_LOAD;
        INST_LOAD:  state_d = IDLE;
        IDLE:       state_d = OP_ADDR;
        OP_ADDR:    state_d = OP_FETCH;
        OP_FETCH:   state_d = ALU_OP;
        ALU_OP:     state_d = STORE;
        default:    state_d = INST_ADDR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wait_cnt   <= '0;
      bus_err    <= 1'b0;
      held_phase <= 3'd0;
    end else begin
      if (stall && !timeout) wait_cnt <= wait_cnt + 1'b1;
      else                   wait_cnt <= '0;
      if (timeout)                             bus_err <= 1'b1;
      else if ((state_q == HALTED) && resume)  bus_err <= 1'b0;
      // Phase index is frozen on entry to HALTED so software can see where it stopped.
      if (state_q != HALTED) held_phase <= state_q[2:0];
    end
  end

`ifdef CONTROL_SEQ_PERF_EN
  logic retire;
  assign retire = ((state_q == STORE) && (state_d == INST_ADDR)) ||
                  ((state_q == OP_ADDR) && (state_d == HALTED));

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)       instr_cnt <= '0;
    else if (retire) instr_cnt <= instr_cnt + 1'b1;
  end
`endif

endmodule
